// File: rtl/uart_tx_arbiter_pkg.sv
// Shared encodings for the UART transmit arbiter; ST_GAP exists only under UART_ARB_GAP_EN.
package uart_arb_pkg;
   localparam int BYTE_W  = 8;
   localparam int GRANT_W = 3;
   localparam int MAX_REQ = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_START   = 3'd2,
      ST_WAIT_HI = 3'd3,
      ST_WAIT_LO = 3'd4
`ifdef UART_ARB_GAP_EN
      , ST_GAP   = 3'd5
`endif
   } state_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of valid scanning ptr, ptr+1, ... mod NUM_REQ.
// Zero latency; no backpressure of its own.
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [GRANT_W-1:0] ptr,
   output logic               any,
   output logic [GRANT_W-1:0] index
);
   logic [2*NUM_REQ-1:0] dbl;
   logic [GRANT_W:0]     sum;

   always_comb begin
      any   = |valid;
      index = '0;
      sum   = '0;
      // rotate so bit 0 is the requester at ptr; scan downwards so the nearest wins
      dbl   = {valid, valid} >> ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (dbl[k]) begin
            sum = {1'b0, ptr} + (GRANT_W + 1)'(k);
            if (sum >= (GRANT_W + 1)'(NUM_REQ)) begin
               sum = sum - (GRANT_W + 1)'(NUM_REQ);
            end
            index = sum[GRANT_W-1:0];
         end
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet round-robin arbiter feeding one 8N2 transmitter; tx_start 1 clk after accept, holds grant until last/MAX_PKT_LEN.
// Requesters see ready only in LOAD; optional inter-packet idle gap under UART_ARB_GAP_EN.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int MAX_PKT_LEN = 64,
   parameter int GAP_CYCLES  = 250
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [BYTE_W*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      tx_start,
   output logic [BYTE_W-1:0]         tx_data,
   input  logic                      tx_busy,
   output logic [GRANT_W-1:0]        grant_id,
   output logic                      grant_active
);
   state_t              state;
   logic [GRANT_W-1:0]  ptr;
   logic [7:0]          cnt;
   logic                lastflag;
   logic                pick_any;
   logic [GRANT_W-1:0]  pick_idx;
   logic                cur_valid;
   logic                cur_last;
   logic [BYTE_W-1:0]   cur_data;
   logic [GRANT_W-1:0]  next_ptr;
`ifdef UART_ARB_GAP_EN
   logic [15:0]         gap_cnt;
`endif

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .valid (req_valid),
      .ptr   (ptr),
      .any   (pick_any),
      .index (pick_idx)
   );

   always_comb begin
      cur_valid = 1'b0;
      cur_last  = 1'b0;
      cur_data  = '0;
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == GRANT_W'(i)) begin
            cur_valid    = req_valid[i];
            cur_last     = req_last[i];
            cur_data     = req_data[BYTE_W*i +: BYTE_W];
            req_ready[i] = (state == ST_LOAD);
         end
      end
      next_ptr = (grant_id == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         ptr          <= '0;
         cnt          <= '0;
         lastflag     <= 1'b0;
         tx_start     <= 1'b0;
         tx_data      <= '0;
         grant_id     <= '0;
         grant_active <= 1'b0;
`ifdef UART_ARB_GAP_EN
         gap_cnt      <= '0;
`endif
      end else begin
         tx_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               // busy check also covers a frame still in flight across a reset
               if (!tx_busy && pick_any) begin
                  grant_id     <= pick_idx;
                  grant_active <= 1'b1;
                  cnt          <= '0;
                  state        <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (cur_valid) begin
                  tx_data  <= cur_data;
                  lastflag <= cur_last || (({1'b0, cnt} + 9'd1) == 9'(MAX_PKT_LEN));
                  cnt      <= cnt + 8'd1;
                  tx_start <= 1'b1;
                  state    <= ST_START;
               end
            end
            ST_START: state <= ST_WAIT_HI;
            ST_WAIT_HI: begin
               if (tx_busy) state <= ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
               if (!tx_busy) begin
                  if (lastflag) begin
                     ptr          <= next_ptr;
                     grant_active <= 1'b0;
`ifdef UART_ARB_GAP_EN
                     gap_cnt      <= '0;
                     state        <= ST_GAP;
`else
                     state        <= ST_IDLE;
`endif
                  end else begin
                     state <= ST_LOAD;
                  end
               end
            end
`ifdef UART_ARB_GAP_EN
            ST_GAP: begin
               if (gap_cnt == 16'(GAP_CYCLES - 1)) state <= ST_IDLE;
               else gap_cnt <= gap_cnt + 16'd1;
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: byte-queue round-robin model, transmitter busy model, directed packet scenarios.
module tb_uart_tx_arbiter;
   localparam int N     = 4;
   localparam int MAXL  = 4;
   localparam int GAP   = 20;
   localparam int FRAME = 12;
`ifdef UART_ARB_GAP_EN
   localparam int MINLOW = GAP + 1;
`else
   localparam int MINLOW = 1;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic           tx_start;
   logic [7:0]     tx_data;
   logic           tx_busy;
   logic [2:0]     grant_id;
   logic           grant_active;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(N), .MAX_PKT_LEN(MAXL), .GAP_CYCLES(GAP)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .tx_busy      (tx_busy),
      .grant_id     (grant_id),
      .grant_active (grant_active)
   );

   int total = 0;
   int bad   = 0;

   logic [8:0]   sq[N][$];     // source queues {last,data}, popped on handshake
   logic [8:0]   mq[N][$];     // model queues, popped on transmit
   logic [N-1:0] en = '1;
   logic [N-1:0] pend = '0;
   int           mptr = 0;
   int           mcur = -1;
   int           mcnt = 0;
   int           starts = 0;
   int           gseq[$];
   logic [7:0]   txq[$];
   int           runs[$];
   int           lowrun = 0;
   bit           fell = 0;
   bit           prev_ga = 0;
   logic [7:0]   held = '0;
   bit           hold_ok = 0;
   int           busy_cnt = 0;

   logic [7:0] exp_t1[3]  = '{8'h55, 8'hA3, 8'h0F};
   logic [7:0] exp_t2[13] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h31, 8'h32, 8'h0A,
                              8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29};
   int         gid_t2[13] = '{2, 2, 2, 2, 3, 3, 0, 2, 2, 2, 2, 2, 2};
   logic [7:0] exp_t3[3]  = '{8'h71, 8'h72, 8'h73};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int r, input logic [7:0] d, input bit l);
      sq[r].push_back({l, d});
      mq[r].push_back({l, d});
   endtask

   // Round-robin rule on whole packets: each new packet goes to the first
   // requester with pending bytes at or after the pointer.
   task automatic model_start();
      logic [8:0] e;
      if (mcur < 0) begin
         for (int k = 0; k < N; k++) begin
            if (mcur < 0 && mq[(mptr + k) % N].size() > 0) mcur = (mptr + k) % N;
         end
         mcnt = 0;
      end
      starts++;
      txq.push_back(tx_data);
      if (mcur < 0) begin
         chk("unexpected_start", tx_start, 0);
         gseq.push_back(-1);
      end else begin
         e = mq[mcur].pop_front();
         chk("tx_data", tx_data, e[7:0]);
         chk("grant_id", grant_id, mcur);
         gseq.push_back(mcur);
         mcnt++;
         if (e[8] || mcnt == MAXL) begin
            mptr = (mcur + 1) % N;
            mcur = -1;
         end
      end
   endtask

   // Per-cycle compare, transmitter model and source drivers, all on the falling edge.
   initial begin
      logic [8:0] h;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      tx_busy   = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (req_ready != '0) begin
               chk("ready_onehot", $onehot(req_ready), 1);
               chk("ready_owner", req_ready, 32'(1) << grant_id);
               chk("ready_granted", grant_active, 1);
            end
            if (tx_start) begin
               chk("start_line_idle", tx_busy, 0);
               chk("start_granted", grant_active, 1);
               model_start();
            end else if (tx_busy && hold_ok) begin
               chk("data_stable", tx_data, held);
            end
            if (grant_active && !prev_ga && fell) begin
               runs.push_back(lowrun);
               chk("min_idle_run", lowrun >= MINLOW, 1);
            end
            if (!grant_active) begin
               if (prev_ga) begin
                  fell   = 1;
                  lowrun = 1;
               end else begin
                  lowrun++;
               end
            end
            prev_ga = grant_active;
         end
         if (tx_start && !rst) begin
            tx_busy  = 1'b1;
            busy_cnt = FRAME;
            held     = tx_data;
            hold_ok  = 1;
         end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
         end
         for (int i = 0; i < N; i++) begin
            if (pend[i] && sq[i].size() > 0) void'(sq[i].pop_front());
         end
         for (int i = 0; i < N; i++) begin
            req_valid[i] = en[i] && (sq[i].size() > 0);
            if (req_valid[i]) begin
               h = sq[i][0];
               req_data[8*i +: 8] = h[7:0];
               req_last[i]        = h[8];
            end else begin
               req_data[8*i +: 8] = 8'h00;
               req_last[i]        = 1'b0;
            end
         end
         pend = req_valid & req_ready;
      end
   end

   task automatic wait_starts(input int n, input string name);
      int c = 0;
      while (starts < n && c < 3000) begin
         @(posedge clk);
         #1;
         c++;
      end
      chk({"starts_", name}, starts, n);
   endtask

   task automatic wait_idle(input string name);
      int c = 0;
      bit busyq;
      busyq = 1;
      while (busyq && c < 3000) begin
         @(posedge clk);
         #1;
         c++;
         busyq = grant_active || tx_busy;
         for (int i = 0; i < N; i++) if (mq[i].size() > 0) busyq = 1;
      end
      chk({"idle_", name}, grant_active, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1);
   end

   initial begin
      int base;
      int c;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_grant_active", grant_active, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // single requester, three bytes
      base = starts;
      push(1, 8'h55, 0);
      push(1, 8'hA3, 0);
      push(1, 8'h0F, 1);
      wait_starts(base + 3, "single");
      wait_idle("single");
      for (int i = 0; i < 3; i++) begin
         chk("single_byte", txq[base + i], exp_t1[i]);
         chk("single_gid", gseq[base + i], 1);
      end

      // forced release at MAX_PKT_LEN with other requesters waiting
      base = starts;
      for (int k = 0; k < 10; k++) push(2, 8'h20 + 8'(k), k == 9);
      push(3, 8'h31, 0);
      push(3, 8'h32, 1);
      push(0, 8'h0A, 1);
      wait_starts(base + 13, "forced");
      wait_idle("forced");
      for (int i = 0; i < 13; i++) begin
         chk("forced_byte", txq[base + i], exp_t2[i]);
         chk("forced_gid", gseq[base + i], gid_t2[i]);
      end

      // requester stalls mid-packet; grant must be held
      base = starts;
      push(1, 8'h71, 0);
      push(1, 8'h72, 0);
      push(1, 8'h73, 1);
      wait_starts(base + 1, "stall_first");
      en[1] = 1'b0;
      repeat (100) begin
         @(posedge clk);
         #1;
         chk("stall_no_start", tx_start, 0);
         chk("stall_grant_held", grant_active, 1);
         chk("stall_other_ready", req_ready & 4'b1101, 0);
      end
      chk("stall_starts", starts, base + 1);
      en[1] = 1'b1;
      wait_starts(base + 3, "stall_rest");
      wait_idle("stall");
      for (int i = 0; i < 3; i++) chk("stall_byte", txq[base + i], exp_t3[i]);

      // reset while a frame is in flight
      base = starts;
      push(0, 8'h41, 0);
      push(0, 8'h42, 1);
      wait_starts(base + 1, "rst_first");
      chk("rst_frame_busy", tx_busy, 1);
      for (int i = 0; i < N; i++) begin
         sq[i].delete();
         mq[i].delete();
      end
      mcur    = -1;
      mptr    = 0;
      hold_ok = 0;
      fell    = 0;
      prev_ga = 0;
      rst     = 1'b1;
      #1;
      chk("midrst_tx_start", tx_start, 0);
      chk("midrst_tx_data", tx_data, 0);
      chk("midrst_req_ready", req_ready, 0);
      chk("midrst_grant_id", grant_id, 0);
      chk("midrst_grant_active", grant_active, 0);
      push(3, 8'h5C, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      c = 0;
      while (tx_busy && c < 100) begin
         chk("midrst_no_grant", grant_active, 0);
         @(posedge clk);
         #1;
         c++;
      end
      base = starts;
      wait_starts(base + 1, "rst_after");
      wait_idle("rst_after");
      chk("midrst_byte", txq[base], 8'h5C);
      chk("midrst_gid", gseq[base], 3);

      // all four contend from a zero pointer
      base = starts;
      runs.delete();
      for (int i = 0; i < N; i++) begin
         push(i, 8'h80 + 8'(2 * i), 0);
         push(i, 8'h81 + 8'(2 * i), 1);
      end
      wait_starts(base + 8, "contend");
      wait_idle("contend");
      for (int i = 0; i < 8; i++) begin
         chk("contend_byte", txq[base + i], 8'h80 + 8'(i));
         chk("contend_gid", gseq[base + i], i / 2);
      end
      chk("contend_runs", runs.size(), 4);
      for (int i = 1; i < 4; i++) begin
         if (i < runs.size()) chk("contend_idle_run", runs[i], MINLOW);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
